// File: rtl/rat_io_pkg.sv
// rat_io_pkg: shared RAT I/O port IDs, control bit indices and interrupt FSM states
package rat_io_pkg;
  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] BTN_CTRL_ID = 8'h41;
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int CTRL_REL_EN_BIT = 2;
  typedef enum logic {IDLE, PULSE} intr_state_t;
endpackage

// File: rtl/rat_debounce.sv
// rat_debounce: two-flop synchroniser plus counter debouncer for one raw button
module rat_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic BTN_IN,
  output logic LEVEL
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, level_q, level_d, diff, done;
  logic [W-1:0] cnt_q, cnt_d;
  // count edges where the synchronised input disagrees with the stable level; any agreement restarts
  always_comb begin
    diff    = sync2_q != level_q;
    done    = diff && cnt_q == LAST;
    level_d = done ? sync2_q : level_q;
    cnt_d   = (!diff || done) ? '0 : cnt_q + 1'b1;
  end
  // synchroniser, stable level and debounce counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= BTN_IN;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
  assign LEVEL = level_q;
endmodule

// File: rtl/rat_btn_intr.sv
// rat_btn_intr: debounced button press counter and fixed-width INTR pulser; RAT_BTN_RELEASE_INTR_EN adds release interrupts
module rat_btn_intr
  import rat_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES   = 1_000_000,
  parameter int          INTR_PULSE_CYCLES = 4,
  parameter logic [7:0]  CTRL_ID           = BTN_CTRL_ID
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_IN,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic       BTN_LEVEL,
  output logic [7:0] PRESS_CNT,
  output logic       INTR
);
  localparam int PW = $clog2(INTR_PULSE_CYCLES);
  localparam logic [PW-1:0] PLOAD = PW'(INTR_PULSE_CYCLES - 1);
  logic level, level_q, wr, press, trig, en_q, en_d;
  logic [7:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  intr_state_t state_q, state_d;
  rat_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .BTN_IN  (BTN_IN),
    .LEVEL   (level)
  );
  assign wr    = IO_STRB && PORT_ID == CTRL_ID;
  assign press = level && !level_q;
`ifdef RAT_BTN_RELEASE_INTR_EN
  logic rel_en_q, rel_en_d, ctrl_unused;
  assign ctrl_unused = ^OUT_PORT[7:3];
  // release-enable register and trigger from either enabled edge
  always_comb begin
    rel_en_d = wr ? OUT_PORT[CTRL_REL_EN_BIT] : rel_en_q;
    trig     = (press && en_q) || (!level && level_q && rel_en_q);
  end
  // release-enable storage
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rel_en_q <= 1'b0;
    else          rel_en_q <= rel_en_d;
  end
`else
  logic ctrl_unused;
  assign ctrl_unused = ^{OUT_PORT[7:3], OUT_PORT[CTRL_REL_EN_BIT]};
  assign trig = press && en_q;
`endif
  // control write, press counter with clear priority, and pulse FSM next state
  always_comb begin
    en_d    = wr ? OUT_PORT[CTRL_EN_BIT] : en_q;
    cnt_d   = (wr && OUT_PORT[CTRL_CLR_BIT]) ? 8'h00 : press ? cnt_q + 8'h01 : cnt_q;
    state_d = state_q == IDLE ? (trig ? PULSE : IDLE) : (pcnt_q == '0 ? IDLE : PULSE);
    pcnt_d  = state_q == IDLE ? (trig ? PLOAD : '0) : (pcnt_q == '0 ? '0 : pcnt_q - 1'b1);
  end
  // edge history, counter, enable and FSM registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= 1'b0;
      cnt_q   <= 8'h00;
      en_q    <= 1'b0;
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      level_q <= level;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end
  assign BTN_LEVEL = level;
  assign PRESS_CNT = cnt_q;
  assign INTR      = state_q == PULSE;
endmodule

// File: tb/tb_rat_btn_intr.sv
// tb_rat_btn_intr: directed self-checking bench for rat_btn_intr with 4-cycle debounce and pulse
module tb_rat_btn_intr;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN_IN = 1'b0;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic       BTN_LEVEL;
  logic [7:0] PRESS_CNT;
  logic       INTR;
  int n_pass = 0;
  int n_total = 0;
  logic seen;
  rat_btn_intr #(.DEBOUNCE_CYCLES(4), .INTR_PULSE_CYCLES(4)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .BTN_IN    (BTN_IN),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .BTN_LEVEL (BTN_LEVEL),
    .PRESS_CNT (PRESS_CNT),
    .INTR      (INTR)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic wr_port(input logic [7:0] id, input logic [7:0] d);
    PORT_ID = id;
    OUT_PORT = d;
    IO_STRB = 1'b1;
    tick(1);
    IO_STRB = 1'b0;
  endtask
  task automatic press(output logic s);
    s = 1'b0;
    BTN_IN = 1'b1;
    repeat (8) begin tick(1); s |= INTR; end
    BTN_IN = 1'b0;
    repeat (12) begin tick(1); s |= INTR; end
  endtask
  initial begin
    tick(2);
    chk("rst_level", {7'b0, BTN_LEVEL}, 8'h00);
    chk("rst_cnt", PRESS_CNT, 8'h00);
    chk("rst_intr", {7'b0, INTR}, 8'h00);
    RESET_N = 1'b1;
    tick(20);
    chk("idle_level", {7'b0, BTN_LEVEL}, 8'h00);
    chk("idle_intr", {7'b0, INTR}, 8'h00);
    wr_port(8'h41, 8'h01);
    BTN_IN = 1'b1;
    tick(5);
    chk("t2_level_early", {7'b0, BTN_LEVEL}, 8'h00);
    tick(1);
    chk("t2_level_rise", {7'b0, BTN_LEVEL}, 8'h01);
    chk("t2_intr_pre", {7'b0, INTR}, 8'h00);
    tick(1);
    chk("t2_cnt", PRESS_CNT, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("t2_intr_high", {7'b0, INTR}, 8'h01);
      tick(1);
    end
    chk("t2_intr_end", {7'b0, INTR}, 8'h00);
    BTN_IN = 1'b0;
    tick(8);
    chk("t2_release_level", {7'b0, BTN_LEVEL}, 8'h00);
    chk("t2_release_intr", {7'b0, INTR}, 8'h00);
    BTN_IN = 1'b1; tick(2);
    BTN_IN = 1'b0; tick(2);
    BTN_IN = 1'b1; tick(2);
    BTN_IN = 1'b0; tick(2);
    chk("t3_bounce_level", {7'b0, BTN_LEVEL}, 8'h00);
    BTN_IN = 1'b1;
    tick(5);
    chk("t3_level_early", {7'b0, BTN_LEVEL}, 8'h00);
    tick(1);
    chk("t3_level_rise", {7'b0, BTN_LEVEL}, 8'h01);
    tick(1);
    chk("t3_cnt", PRESS_CNT, 8'h02);
    chk("t3_intr", {7'b0, INTR}, 8'h01);
    tick(4);
    chk("t3_intr_end", {7'b0, INTR}, 8'h00);
    BTN_IN = 1'b0;
    tick(8);
    wr_port(8'h41, 8'h02);
    chk("t4_clear", PRESS_CNT, 8'h00);
    for (int i = 0; i < 3; i++) begin
      press(seen);
      chk("t4_no_intr", {7'b0, seen}, 8'h00);
    end
    chk("t4_cnt3", PRESS_CNT, 8'h03);
    wr_port(8'h40, 8'h02);
    chk("t4_wrong_port", PRESS_CNT, 8'h03);
    wr_port(8'h41, 8'h02);
    chk("t4_clear2", PRESS_CNT, 8'h00);
    press(seen);
    chk("t4_still_disabled", {7'b0, seen}, 8'h00);
    wr_port(8'h41, 8'h02);
    for (int i = 0; i < 255; i++) press(seen);
    chk("t5_cnt_ff", PRESS_CNT, 8'hFF);
    press(seen);
    chk("t5_wrap", PRESS_CNT, 8'h00);
    press(seen);
    chk("t5_cnt1", PRESS_CNT, 8'h01);
    wr_port(8'h41, 8'h01);
    BTN_IN = 1'b1;
    tick(6);
    PORT_ID = 8'h41;
    OUT_PORT = 8'h03;
    IO_STRB = 1'b1;
    tick(1);
    IO_STRB = 1'b0;
    chk("t5_clear_wins", PRESS_CNT, 8'h00);
    chk("t5_clear_intr", {7'b0, INTR}, 8'h01);
    tick(3);
    chk("t5_intr_last", {7'b0, INTR}, 8'h01);
    tick(1);
    chk("t5_intr_end", {7'b0, INTR}, 8'h00);
    BTN_IN = 1'b0;
    tick(12);
    BTN_IN = 1'b1;
    tick(8);
    chk("t6_intr_2nd", {7'b0, INTR}, 8'h01);
    chk("t6_cnt_pre", PRESS_CNT, 8'h01);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_async_intr", {7'b0, INTR}, 8'h00);
    chk("t6_async_cnt", PRESS_CNT, 8'h00);
    BTN_IN = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(10);
    wr_port(8'h41, 8'h05);
    BTN_IN = 1'b1;
    tick(7);
    chk("t6_press_intr", {7'b0, INTR}, 8'h01);
    chk("t6_press_cnt", PRESS_CNT, 8'h01);
    tick(4);
    chk("t6_press_end", {7'b0, INTR}, 8'h00);
    BTN_IN = 1'b0;
    tick(6);
    chk("t6_rel_level", {7'b0, BTN_LEVEL}, 8'h00);
    tick(1);
`ifdef RAT_BTN_RELEASE_INTR_EN
    chk("t6_rel_intr", {7'b0, INTR}, 8'h01);
    tick(3);
    chk("t6_rel_intr_last", {7'b0, INTR}, 8'h01);
`else
    chk("t6_rel_no_intr", {7'b0, INTR}, 8'h00);
    tick(3);
`endif
    tick(1);
    chk("t6_rel_end", {7'b0, INTR}, 8'h00);
    chk("t6_rel_cnt", PRESS_CNT, 8'h01);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rat_btn_intr.md
Name: rat_btn_intr

Overview:
- Button-to-interrupt peripheral that sits on the RAT MCU I/O bus, upstream of the MCU INTR input.
- Synchronises and debounces one raw pushbutton, counts presses, and drives a fixed-width INTR pulse.
- The pulse is wide enough to be caught by the 50 MHz MCU clock.
- Exposes the press count to the wrapper input mux. Accepts a control register write from the wrapper output bus.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: CLK cycles the synchronised input must differ from the stable level before the stable level changes (10 ms at 100 MHz). Must be >= 2.
- INTR_PULSE_CYCLES, 4: CLK cycles INTR is held high per event. Must be >= 2.
- CTRL_ID, 8'h41: output port ID of the control register.

Ports:
- CLK  in  1  100 MHz system clock (the same clock as the wrapper registers).
- RESET_N  in  1  asynchronous active-low reset.
- BTN_IN  in  1  raw, asynchronous, bouncing button.
- PORT_ID  in  8  MCU port ID.
- OUT_PORT  in  8  MCU output data.
- IO_STRB  in  1  MCU output strobe.
- BTN_LEVEL  out  1  debounced button level.
- PRESS_CNT  out  8  press counter, routed to the wrapper input mux.
- INTR  out  1  interrupt request to the MCU.

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops = 0, BTN_LEVEL = 0, debounce counter = 0
  - PRESS_CNT = 0, INTR = 0, pulse counter = 0, ctrl enable bit = 0
  - FSM state = IDLE
- Synchroniser: 2 flops on BTN_IN. The value `sync` is valid 2 edges after a change on BTN_IN.
- Debounce:
  - Each edge where sync != BTN_LEVEL: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != BTN_LEVEL: BTN_LEVEL <= sync and counter <= 0.
  - Any edge where sync == BTN_LEVEL: counter <= 0, so a bounce restarts the count.
  - Net latency: BTN_LEVEL changes DEBOUNCE_CYCLES+2 edges after BTN_IN changes, provided BTN_IN is held steady.
- Event: a press event is the edge where BTN_LEVEL goes 0->1.
  - PRESS_CNT increments modulo 256 (8'hFF -> 8'h00).
- Control register write: occurs when IO_STRB=1 and PORT_ID==CTRL_ID, on that CLK edge.
  - bit0 -> enable (stored).
  - bit1 -> clear PRESS_CNT (self-clearing, not stored).
  - Other bits ignored.
- Same-edge clear and press event: clear wins, so PRESS_CNT = 0. The event still triggers INTR if enabled.
- Interrupt FSM:
  - IDLE: INTR=0. On a press event with enable=1 (enable as registered before this edge) -> go to PULSE, load the pulse counter with INTR_PULSE_CYCLES-1, and set INTR=1 on the next edge.
  - PULSE: INTR=1. The pulse counter decrements each edge. When it reaches 0, the next edge returns to IDLE with INTR=0. INTR is high for exactly INTR_PULSE_CYCLES edges.
  - A press event during PULSE is counted but does not extend or retrigger the pulse.
  - Clearing enable during PULSE does not truncate the pulse.
- Press with enable=0: counted, no INTR.
- RESET_N asserted mid-pulse: INTR drops to 0 immediately (asynchronously).

Optional Feature:
- Macro: RAT_BTN_RELEASE_INTR_EN.
- Defined:
  - ctrl bit2 stores a release-enable.
  - A BTN_LEVEL 1->0 edge with release-enable=1 triggers the same INTR pulse, with the same no-retrigger rule.
  - Releases are never counted.
  - Release-enable resets to 0.
- Undefined: bit2 is ignored, and release edges have no effect.

Decomposition:
- Package rat_io_pkg:
  - port ID constants: SWITCHES_ID 8'h20, LEDS_ID 8'h40, BTN_CTRL_ID 8'h41
  - ctrl bit-index constants: CTRL_EN_BIT 0, CTRL_CLR_BIT 1, CTRL_REL_EN_BIT 2
  - enum type intr_state_t {IDLE, PULSE}
- Sub-module rat_debounce: synchroniser plus debounce counter; parameter DEBOUNCE_CYCLES; ports CLK, RESET_N, BTN_IN, LEVEL.
  - Reusable for additional buttons.
- Edge detect, counter, control register and interrupt FSM stay in the top level.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and INTR_PULSE_CYCLES=4.
1. Reset with RESET_N=0 -> BTN_LEVEL=0, PRESS_CNT=8'h00, INTR=0. Release and hold BTN_IN=0 for 20 cycles -> no change.
2. Write 8'h01 to 8'h41, then hold BTN_IN=1 -> BTN_LEVEL rises 6 edges later, PRESS_CNT=1, and INTR is high for exactly 4 edges starting 1 edge after BTN_LEVEL rises.
3. BTN_IN toggles 1,0,1,0 every 2 cycles, then settles at 1 -> BTN_LEVEL rises once, 6 edges after the final rise, and PRESS_CNT increments by exactly 1.
4. enable=0 with 3 clean presses -> PRESS_CNT=3 and INTR never asserts. Write 8'h02 -> PRESS_CNT=0 on the next edge, enable still 0.
5. PRESS_CNT preloaded to 8'hFF by 255 presses, then 1 more press -> 8'h00. A clear write on the same edge as a press event gives 8'h00 and INTR still fires if enabled.
6. RESET_N pulsed low during the 2nd INTR cycle -> INTR=0 immediately, PRESS_CNT=0. A release with RAT_BTN_RELEASE_INTR_EN defined and ctrl 8'h05 -> 4-cycle INTR on release, with no count change.
